llr_sat_accumulator: RTL and testbench

//   Multi-lane streaming accumulator for signed LLR/min-sum messages with output saturation.

---
 rtl/llr_sat_accumulator.sv | 123 ++++++++++++
 tb/tb_llr_sat_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/llr_sat_accumulator.sv
// Multi-lane streaming accumulator for signed LLR messages. It clamps the extended accumulator
// and saturates each lane to WIDTH bits at group end, counting lane saturation events.
module llr_sat_accumulator #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned EXTENDED_BITS = 4,
    parameter int unsigned LANES         = 4,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic                     in_last,
    input  logic                     sat_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_sat,
    input  logic                     clear_count,
    output logic [COUNT_WIDTH-1:0]   sat_count
);

    localparam int unsigned ACC_W = WIDTH + EXTENDED_BITS;

    localparam logic [WIDTH-1:0] MAXVAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINVAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] NEGMAX = MINVAL + WIDTH'(1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d;
    logic                        first_q;
    logic                        out_valid_q;
    logic [LANES*WIDTH-1:0]      out_data_q, out_data_d;
    logic [LANES-1:0]            out_sat_q, out_sat_d;
    logic [COUNT_WIDTH-1:0]      sat_count_q, sat_count_d;
    logic [COUNT_WIDTH:0]        inc, total;
    logic                        accept, accept_last;

    assign in_ready    = ~out_valid_q | out_ready;
    assign accept      = in_valid & in_ready;
    assign accept_last = accept & in_last;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0]       term;
        logic [ACC_W-1:0]       base;
        logic [ACC_W:0]         sum;
        logic [ACC_W-1:0]       clamped;
        logic [EXTENDED_BITS:0] top;
        logic [WIDTH-1:0]       lane_out;
        logic                   lane_sat;

        assign term = in_data[i*WIDTH +: WIDTH];
        assign base = first_q ? '0 : acc_q[i];
        assign sum  = {base[ACC_W-1], base} + {{(EXTENDED_BITS+1){term[WIDTH-1]}}, term};

        // One extra bit of headroom: differing top bits mean the sum left the ACC_W range.
        assign clamped = (sum[ACC_W] != sum[ACC_W-1]) ? (sum[ACC_W] ? ACC_MIN : ACC_MAX)
                                                      : sum[ACC_W-1:0];
        assign top     = clamped[ACC_W-1 -: EXTENDED_BITS+1];

        always_comb begin
            lane_out = clamped[WIDTH-1:0];
            lane_sat = 1'b0;
            if (!(&top || ~|top)) begin
                lane_sat = 1'b1;
                lane_out = clamped[ACC_W-1] ? (sat_mode ? MINVAL : NEGMAX) : MAXVAL;
            end else if (!sat_mode && clamped[WIDTH-1:0] == MINVAL) begin
                lane_sat = 1'b1;
                lane_out = NEGMAX;
            end
        end

        assign acc_d[i]                      = clamped;
        assign out_data_d[i*WIDTH +: WIDTH]  = lane_out;
        assign out_sat_d[i]                  = lane_sat;
    end

    always_comb begin
        inc = '0;
        for (int i = 0; i < LANES; i++) begin
            inc = inc + (COUNT_WIDTH+1)'(out_sat_d[i]);
        end
        total       = {1'b0, sat_count_q} + inc;
        sat_count_d = sat_count_q;
        if (clear_count) begin
            sat_count_d = '0;
        end else if (accept_last) begin
            sat_count_d = total[COUNT_WIDTH] ? '1 : total[COUNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
            if (accept) begin
                acc_q   <= acc_d;
                first_q <= in_last;
            end
            if (accept_last) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_data_d;
                out_sat_q   <= out_sat_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_llr_sat_accumulator.sv
// Scoreboard bench for llr_sat_accumulator: directed scenarios plus random groups against an
// integer reference model of group sums, clamping and output saturation.
module tb_llr_sat_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        sat_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_sat;
    logic        clear_count = 1'b0;
    logic [15:0] sat_count;

    llr_sat_accumulator #(
        .WIDTH(8), .EXTENDED_BITS(4), .LANES(4), .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .sat_mode(sat_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .clear_count(clear_count), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  sat;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   failures = 0;

    int m_acc[4];
    bit m_first = 1'b1;
    bit m_ov = 1'b0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int e);
        logic [31:0] r;
        r[7:0]   = a[7:0];
        r[15:8]  = b[7:0];
        r[23:16] = c[7:0];
        r[31:24] = e[7:0];
        return r;
    endfunction

    // One clock cycle: drive, predict, let the edge happen, check state-like outputs.
    task automatic cycle(input bit v, input logic [31:0] d, input bit last, input bit mode,
                         input bit ordy, input bit clr);
        bit   exp_rdy, acc;
        int   pop, s, o;
        bit   sf;
        res_t r;
        r = '0;
        in_valid = v; in_data = d; in_last = last; sat_mode = mode;
        out_ready = ordy; clear_count = clr;
        #1;
        exp_rdy = !m_ov || ordy;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        acc = v && exp_rdy;
        pop = 0;
        if (acc) begin
            for (int i = 0; i < 4; i++) begin
                s = (m_first ? 0 : m_acc[i]) + int'($signed(d[i*8 +: 8]));
                if (s > 2047) s = 2047;
                if (s < -2048) s = -2048;
                m_acc[i] = s;
                if (last) begin
                    sf = 1'b1;
                    if (s > 127) o = 127;
                    else if (s < -128) o = mode ? -128 : -127;
                    else if (s == -128 && !mode) o = -127;
                    else begin o = s; sf = 1'b0; end
                    r.data[i*8 +: 8] = o[7:0];
                    r.sat[i] = sf;
                    pop += int'(sf);
                end
            end
            m_first = last;
            if (last) sb.push_back(r);
        end
        if (clr) m_cnt = 0;
        else if (acc && last) m_cnt = (m_cnt + pop > 65535) ? 65535 : m_cnt + pop;
        if (acc && last) m_ov = 1'b1;
        else if (ordy) m_ov = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        chk("sat_count", {48'd0, sat_count}, 64'(m_cnt));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; clear_count = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_sat", {60'd0, out_sat}, 64'd0);
        chk("rst_sat_count", {48'd0, sat_count}, 64'd0);
        for (int i = 0; i < 4; i++) m_acc[i] = 0;
        m_first = 1'b1; m_ov = 1'b0; m_cnt = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    // Monitor: whenever a result is presented, compare with the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got data %0h with no expected result", out_data);
                end else begin
                    chk("out_data", {32'd0, out_data}, {32'd0, sb[0].data});
                    chk("out_sat", {60'd0, out_sat}, {60'd0, sb[0].sat});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        do_reset();

        // 1: single in-range beat
        cycle(1'b1, pk(100, -5, 0, 127), 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t1_data", {32'd0, out_data}, {32'd0, pk(100, -5, 0, 127)});
        chk("t1_sat", {60'd0, out_sat}, 64'd0);
        idle(2);

        // 2: positive and negative saturation in both modes
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 3; k++)
                cycle(1'b1, pk(m == 0 ? 100 : -100, 0, 0, 0), k == 2, m == 2, 1'b1, 1'b0);
            chk("t2_lane0", {56'd0, out_data[7:0]},
                {56'd0, m == 0 ? 8'd127 : (m == 1 ? 8'h81 : 8'h80)});
            chk("t2_sat", {60'd0, out_sat}, 64'd1);
        end
        idle(2);

        // 3: -128 remapped only in symmetric mode
        cycle(1'b1, pk(-128, 0, 0, 0), 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t3_sym", {56'd0, out_data[7:0]}, 64'h81);
        cycle(1'b1, pk(-128, 0, 0, 0), 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t3_full", {56'd0, out_data[7:0]}, 64'h80);
        chk("t3_full_sat", {60'd0, out_sat}, 64'd0);
        idle(2);

        // 4: extended register clamps at 2047 instead of wrapping
        for (int k = 0; k < 20; k++) cycle(1'b1, pk(0, 127, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) cycle(1'b1, pk(0, -128, 0, 0), k == 15, 1'b0, 1'b1, 1'b0);
        chk("t4_lane1", {56'd0, out_data[15:8]}, 64'hff);
        chk("t4_sat", {60'd0, out_sat}, 64'd0);
        idle(2);

        // 5: backpressure holds the result, then release with a new last beat in the same cycle
        cycle(1'b1, pk(1, 2, 3, 4), 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, pk(9, 9, 9, 9), 1'b1, 1'b0, 1'b0, 1'b0);
            chk("t5_hold", {32'd0, out_data}, {32'd0, pk(1, 2, 3, 4)});
        end
        cycle(1'b1, pk(5, 6, 7, 8), 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_new", {32'd0, out_data}, {32'd0, pk(5, 6, 7, 8)});
        idle(2);

        // 6: reset discards a partial group; clear_count beats a same-cycle increment
        cycle(1'b1, pk(100, 0, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, pk(100, 0, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();
        cycle(1'b1, pk(3, 0, 0, 0), 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6_lane0", {56'd0, out_data[7:0]}, 64'd3);
        cycle(1'b1, pk(-128, -128, 0, 0), 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, pk(-128, 0, 0, 0), 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t6_clear", {48'd0, sat_count}, 64'd0);
        idle(2);

        // Random groups with random backpressure
        for (int k = 0; k < 800; k++) begin
            logic [31:0] d;
            d = $urandom;
            cycle(($urandom % 5) != 0, d, ($urandom % 4) == 0, $urandom % 2,
                  ($urandom % 4) != 0, ($urandom % 60) == 0);
        end
        idle(4);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
